// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx_scheduler_pkg                                      |
// | Brief    : Shared FSM encoding and grant width for uart_tx_scheduler  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package uart_tx_scheduler_pkg;

  localparam int GRANT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_ACK       = 3'd4
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arbiter                                                 |
// | Brief    : Combinational requester picker; round-robin from ptr+1, or |
// |            lowest-index-first when UART_TX_SCHED_FIXED_PRIO_EN is set |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [N_REQ-1:0]   onehot,
  output logic [GRANT_W-1:0] index
);

  logic w_found;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr;

  always_comb begin
    onehot  = '0;
    index   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[i]) begin
        w_found   = 1'b1;
        onehot[i] = 1'b1;
        index     = GRANT_W'(i);
      end
    end
  end
`else
  // Walk offsets 1..N_REQ from the last winner so the previous winner is
  // considered last; it still wins when it is the only requester.
  always_comb begin
    onehot  = '0;
    index   = '0;
    w_found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_found && req[i] && (i == (int'(ptr) + off) % N_REQ)) begin
          w_found   = 1'b1;
          onehot[i] = 1'b1;
          index     = GRANT_W'(i);
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx_scheduler                                          |
// | Brief    : Shares one uart_transmitter among N_REQ byte requesters;   |
// |            UART_TX_SCHED_FIXED_PRIO_EN selects fixed priority         |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 2047,
  parameter int TO_W         = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic                 ack_err,
  output logic                 ut_send,
  output logic [7:0]           ut_data,
  input  logic                 ut_busy,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 idle
);

  localparam logic [GRANT_W-1:0] c_ptr_rst = GRANT_W'(N_REQ - 1);
  localparam logic [TO_W-1:0]    c_timeout = TO_W'(BUSY_TIMEOUT);

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;
  logic [TO_W-1:0]    r_cnt;
  logic [TO_W-1:0]    w_cnt_nxt;
  logic               r_err;
  logic [GRANT_W-1:0] r_grant;
  logic [GRANT_W-1:0] r_ptr;
  logic [7:0]         r_data;
  logic [N_REQ-1:0]   w_win_onehot;
  logic [GRANT_W-1:0] w_win_index;
  logic [7:0]         w_win_byte;
  logic               w_take;
  logic               w_timeout;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req    (req),
    .ptr    (r_ptr),
    .onehot (w_win_onehot),
    .index  (w_win_index)
  );

  always_comb begin
    w_win_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win_onehot[i]) begin
        w_win_byte = req_data[8*i +: 8];
      end
    end
  end

  assign w_cnt_nxt = r_cnt + TO_W'(1);
  assign w_timeout = (w_cnt_nxt == c_timeout);

  // A busy level seen in IDLE belongs to someone else; wait it out.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((|req) && !ut_busy) begin
          w_take      = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND:      w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (ut_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (w_timeout) begin
          w_state_nxt = S_ACK;
        end
      end
      S_WAIT_DONE: begin
        if (!ut_busy) begin
          w_state_nxt = S_ACK;
        end
      end
      S_ACK:       w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_grant <= '0;
      r_data  <= 8'h00;
      r_ptr   <= c_ptr_rst;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_grant <= w_win_index;
        r_data  <= w_win_byte;
      end
      if (r_state == S_SEND) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if ((r_state == S_WAIT_BUSY) && !ut_busy) begin
        r_cnt <= w_cnt_nxt;
        if (w_timeout) begin
          r_err <= 1'b1;
        end
      end
      if (r_state == S_ACK) begin
        r_ptr <= r_grant;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
      assign ack[gi] = (r_state == S_ACK) && (r_grant == GRANT_W'(gi));
    end
  endgenerate

  assign ack_err  = (r_state == S_ACK) && r_err;
  assign ut_send  = (r_state == S_SEND);
  assign ut_data  = r_data;
  assign grant_id = r_grant;
  assign idle     = (r_state == S_IDLE);

endmodule
`default_nettype wire
